// File: rtl/bp_fe_queue_checkpoint_fifo_if.sv
// FE-to-BE queue handshake bundle.
//   master : the FE/BE side driving packets and clr/roll/deq/yumi controls
//   slave  : the checkpoint FIFO itself
// Signals:
//   fe_queue_i / fe_queue_v_i   packet and valid from FE fetch
//   fe_queue_ready_o            space available and no clear this cycle
//   fe_queue_o / fe_queue_v_o   packet at the read pointer, unread entry present
//   fe_queue_yumi_i             BE consumes fe_queue_o
//   fe_queue_clr_i              discard all unread entries
//   fe_queue_roll_i             rewind read pointer to the commit pointer
//   fe_queue_deq_i              retire the oldest read entry
//   count_o                     entries held, committed-to-write
interface bp_fe_queue_checkpoint_fifo_if #(
    parameter int els_p   = 8,
    parameter int width_p = 128
);
    localparam int ptr_width_lp = $clog2(els_p) + 1;

    logic [width_p-1:0]      fe_queue_i;
    logic                    fe_queue_v_i;
    logic                    fe_queue_ready_o;
    logic [width_p-1:0]      fe_queue_o;
    logic                    fe_queue_v_o;
    logic                    fe_queue_yumi_i;
    logic                    fe_queue_clr_i;
    logic                    fe_queue_roll_i;
    logic                    fe_queue_deq_i;
    logic [ptr_width_lp-1:0] count_o;

    modport master (
        output fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
               fe_queue_clr_i, fe_queue_roll_i, fe_queue_deq_i,
        input  fe_queue_ready_o, fe_queue_o, fe_queue_v_o, count_o
    );

    modport slave (
        input  fe_queue_i, fe_queue_v_i, fe_queue_yumi_i,
               fe_queue_clr_i, fe_queue_roll_i, fe_queue_deq_i,
        output fe_queue_ready_o, fe_queue_o, fe_queue_v_o, count_o
    );
endinterface

// File: rtl/bp_fe_queue_checkpoint_fifo.sv
// Checkpointing FE queue buffer between fetch and the BE scheduler.
// Entries stay resident after being read (yumi) until retired (deq), so the
// BE can rewind the read pointer (roll) and replay them, or drop all unread
// speculative entries (clr).
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   reset_n_i  asynchronous active-low reset, clears all pointers
//   q          slave side of the fe_queue handshake bundle
// Pointers carry one extra wrap bit so full and empty are distinguishable;
// ordering is always cptr <= rptr <= wptr (modular).
module bp_fe_queue_checkpoint_fifo #(
    parameter int els_p   = 8,
    parameter int width_p = 128
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    bp_fe_queue_checkpoint_fifo_if.slave  q
);
    localparam int idx_width_lp = $clog2(els_p);
    localparam int ptr_width_lp = idx_width_lp + 1;

    typedef logic [ptr_width_lp-1:0] ptr_t;

    logic [width_p-1:0] mem [els_p];

    ptr_t wptr, rptr, cptr;
    ptr_t wptr_n, rptr_n, cptr_n;
    ptr_t used;
    logic full, ready, enq, deq_ok, yumi_ok;

    // Space is only returned on retirement, so occupancy is measured from cptr.
    assign used  = wptr - cptr;
    assign full  = (used == ptr_t'(els_p));
    assign ready = ~full & ~q.fe_queue_clr_i;
    assign enq   = q.fe_queue_v_i & ready;

    // Illegal deq (nothing read) and illegal yumi (nothing unread) are dropped.
    assign deq_ok  = q.fe_queue_deq_i & (cptr != rptr);
    assign yumi_ok = q.fe_queue_yumi_i & (rptr != wptr);

    // Evaluated in dependency order: commit, then read, then write.
    // roll takes priority over yumi; clr collapses the write side onto the
    // (possibly rolled) read pointer.
    assign cptr_n = cptr + ptr_t'(deq_ok);
    assign rptr_n = q.fe_queue_roll_i ? cptr_n : rptr + ptr_t'(yumi_ok);
    assign wptr_n = q.fe_queue_clr_i  ? rptr_n : wptr + ptr_t'(enq);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr <= '0;
            rptr <= '0;
            cptr <= '0;
        end else begin
            wptr <= wptr_n;
            rptr <= rptr_n;
            cptr <= cptr_n;
        end
    end

    // Storage is deliberately not reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (enq)
            mem[wptr[idx_width_lp-1:0]] <= q.fe_queue_i;
    end

    assign q.fe_queue_ready_o = ready;
    assign q.fe_queue_v_o     = (rptr != wptr);
    assign q.fe_queue_o       = mem[rptr[idx_width_lp-1:0]];
    assign q.count_o          = used;

    a_deq_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(q.fe_queue_deq_i && (cptr == rptr)))
        else $error("deq with no read-but-uncommitted entry");

    a_yumi_legal: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        !(q.fe_queue_yumi_i && (rptr == wptr)))
        else $error("yumi while fe_queue_v_o is low");
endmodule

// File: tb/tb_bp_fe_queue_checkpoint_fifo.sv
module tb_bp_fe_queue_checkpoint_fifo;
    localparam int els_p   = 4;
    localparam int width_p = 8;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       yumi;
        logic       clr;
        logic       roll;
        logic       deq;
        logic       e_ready;  // ready_o during the cycle
        logic       e_v;      // v_o after the edge
        logic [2:0] e_cnt;    // count_o after the edge
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Reference: unread packets and read-but-unretired packets, oldest first.
    logic [7:0] pend[$];
    logic [7:0] held[$];
    vec_t       tbl[$];

    always #5 clk = ~clk;

    bp_fe_queue_checkpoint_fifo_if #(.els_p(els_p), .width_p(width_p)) qif ();

    bp_fe_queue_checkpoint_fifo #(.els_p(els_p), .width_p(width_p)) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .q         (qif)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic yumi,
                                input logic clr, input logic roll, input logic deq,
                                input logic e_ready, input logic e_v, input logic [2:0] e_cnt);
        vec_t t;
        t.v = v; t.d = d; t.yumi = yumi; t.clr = clr; t.roll = roll; t.deq = deq;
        t.e_ready = e_ready; t.e_v = e_v; t.e_cnt = e_cnt;
        return t;
    endfunction

    task automatic idle_inputs();
        qif.fe_queue_i      = '0;
        qif.fe_queue_v_i    = 1'b0;
        qif.fe_queue_yumi_i = 1'b0;
        qif.fe_queue_clr_i  = 1'b0;
        qif.fe_queue_roll_i = 1'b0;
        qif.fe_queue_deq_i  = 1'b0;
    endtask

    // Called just after a rising edge; drives one cycle and checks it.
    task automatic step(input vec_t t);
        logic acc;
        qif.fe_queue_i      = t.d;
        qif.fe_queue_v_i    = t.v;
        qif.fe_queue_yumi_i = t.yumi;
        qif.fe_queue_clr_i  = t.clr;
        qif.fe_queue_roll_i = t.roll;
        qif.fe_queue_deq_i  = t.deq;
        @(negedge clk);
        chk("ready", int'(qif.fe_queue_ready_o), int'(t.e_ready));
        acc = t.v && !t.clr && ((pend.size() + held.size()) < els_p);
        if (t.yumi && pend.size() > 0)
            chk("yumi_data", int'(qif.fe_queue_o), int'(pend[0]));
        @(posedge clk);
        if (t.deq && held.size() > 0) void'(held.pop_front());
        if (t.yumi && pend.size() > 0) held.push_back(pend.pop_front());
        if (t.roll) begin
            pend = {held, pend};
            held.delete();
        end
        if (t.clr) pend.delete();
        if (acc) pend.push_back(t.d);
        #1;
        chk("v", int'(qif.fe_queue_v_o), int'(t.e_v));
        chk("count", int'(qif.count_o), int'(t.e_cnt));
        if (pend.size() > 0)
            chk("head", int'(qif.fe_queue_o), int'(pend[0]));
    endtask

    initial begin
        idle_inputs();
        //                 v  d      y  c  r  q   rdy v  cnt
        // fill to full
        tbl.push_back(mk(1, 8'hA0, 0, 0, 0, 0,  1, 1, 3'd1));
        tbl.push_back(mk(1, 8'hA1, 0, 0, 0, 0,  1, 1, 3'd2));
        tbl.push_back(mk(1, 8'hA2, 0, 0, 0, 0,  1, 1, 3'd3));
        tbl.push_back(mk(1, 8'hA3, 0, 0, 0, 0,  1, 1, 3'd4));
        // read everything without retiring: still full
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,  0, 1, 3'd4));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,  0, 1, 3'd4));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,  0, 1, 3'd4));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,  0, 0, 3'd4));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  0, 0, 3'd3));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 0, 3'd2));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0,  1, 0, 3'd2));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 0, 3'd1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 0, 3'd0));
        // roll replays B0
        tbl.push_back(mk(1, 8'hB0, 0, 0, 0, 0,  1, 1, 3'd1));
        tbl.push_back(mk(1, 8'hB1, 0, 0, 0, 0,  1, 1, 3'd2));
        tbl.push_back(mk(1, 8'hB2, 0, 0, 0, 0,  1, 1, 3'd3));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,  1, 1, 3'd3));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,  1, 1, 3'd3));
        tbl.push_back(mk(0, 8'h00, 0, 0, 1, 0,  1, 1, 3'd3));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,  1, 1, 3'd3));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1,  1, 1, 3'd2));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 1,  1, 0, 3'd1));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 0, 3'd0));
        // clr after one read keeps C0 held
        tbl.push_back(mk(1, 8'hC0, 0, 0, 0, 0,  1, 1, 3'd1));
        tbl.push_back(mk(1, 8'hC1, 0, 0, 0, 0,  1, 1, 3'd2));
        tbl.push_back(mk(1, 8'hC2, 0, 0, 0, 0,  1, 1, 3'd3));
        tbl.push_back(mk(1, 8'hC3, 0, 0, 0, 0,  1, 1, 3'd4));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,  0, 1, 3'd4));
        tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0,  0, 0, 3'd1));
        tbl.push_back(mk(1, 8'hD0, 0, 0, 0, 0,  1, 1, 3'd2));
        tbl.push_back(mk(0, 8'h00, 0, 0, 0, 1,  1, 1, 3'd1));
        // clr blocks a same-cycle enqueue; clr+roll empties everything
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,  1, 0, 3'd1));
        tbl.push_back(mk(1, 8'hEE, 0, 1, 0, 0,  0, 0, 3'd1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0,  0, 0, 3'd0));
        // deq+yumi+enq at full: enqueue refused, accepted next cycle
        tbl.push_back(mk(1, 8'hE0, 0, 0, 0, 0,  1, 1, 3'd1));
        tbl.push_back(mk(1, 8'hE1, 0, 0, 0, 0,  1, 1, 3'd2));
        tbl.push_back(mk(1, 8'hE2, 0, 0, 0, 0,  1, 1, 3'd3));
        tbl.push_back(mk(1, 8'hE3, 0, 0, 0, 0,  1, 1, 3'd4));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0,  0, 1, 3'd4));
        tbl.push_back(mk(1, 8'hF0, 1, 0, 0, 1,  0, 1, 3'd3));
        tbl.push_back(mk(1, 8'hF0, 0, 0, 0, 0,  1, 1, 3'd4));
        tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0,  0, 0, 3'd0));

        // reset state, held in reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_v", int'(qif.fe_queue_v_o), 0);
        chk("rst_ready", int'(qif.fe_queue_ready_o), 1);
        chk("rst_count", int'(qif.count_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) step(tbl[i]);

        // pointer wrap: enqueue / read / retire, data order tracked by the model
        for (int i = 0; i < 10; i++) begin
            step(mk(1, 8'h10 + 8'(i), 0, 0, 0, 0,  1, 1, 3'd1));
            step(mk(0, 8'h00,         1, 0, 0, 0,  1, 0, 3'd1));
            step(mk(0, 8'h00,         0, 0, 0, 1,  1, 0, 3'd0));
        end

        // reset in the middle of traffic, checked before any clock edge
        step(mk(1, 8'h55, 0, 0, 0, 0,  1, 1, 3'd1));
        step(mk(1, 8'h66, 0, 0, 0, 0,  1, 1, 3'd2));
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_v", int'(qif.fe_queue_v_o), 0);
        chk("midrst_ready", int'(qif.fe_queue_ready_o), 1);
        chk("midrst_count", int'(qif.count_o), 0);
        pend.delete();
        held.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(mk(1, 8'h77, 0, 0, 0, 0,  1, 1, 3'd1));
        step(mk(0, 8'h00, 1, 0, 0, 0,  1, 0, 3'd1));
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
